// File: rtl/paralelo_serial_idl_param.sv
// Parallel-to-serial transmitter: one bit per clk_32f cycle, idle-word insertion
// whenever no data word is accepted at a word boundary, and a post-reset idle preamble.
module paralelo_serial_idl_param #(
    parameter int unsigned WIDTH     = 8,
    parameter logic [31:0] IDLE_WORD = 32'h0000_00BC,
    parameter int unsigned MIN_IDLE  = 4,
    parameter bit          LSB_FIRST = 1'b0
) (
    input  logic             clk_32f,
    input  logic             reset,
    input  logic             active,
    input  logic             valid_in,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             data_out,
    output logic             IDL
);

    localparam int unsigned CNT_W  = $clog2(WIDTH);
    localparam int unsigned IDLE_W = (MIN_IDLE < 1) ? 1 : $clog2(MIN_IDLE + 1);
    localparam logic [WIDTH-1:0] IDLE_VAL = IDLE_WORD[WIDTH-1:0];

    logic [CNT_W-1:0]  r_bit_cnt;
    logic [IDLE_W-1:0] r_idle_cnt;
    logic [WIDTH-1:0]  r_shift;
    logic              r_data_out;
    logic              r_idl;

    logic              w_load;
    logic              w_idle_done;
    logic              w_ready;
    logic              w_take;
    logic [WIDTH-1:0]  w_src;
    logic [WIDTH-1:0]  w_shift_nxt;
    logic              w_bit_nxt;
    logic [CNT_W-1:0]  w_bit_cnt_nxt;
    logic [IDLE_W-1:0] w_idle_cnt_nxt;
    logic              w_idl_nxt;

    // Idle preamble is complete once MIN_IDLE idle words have been loaded.
    generate
        if (MIN_IDLE == 0) begin : g_no_preamble
            assign w_idle_done = 1'b1;
        end else begin : g_preamble
            assign w_idle_done = (r_idle_cnt >= IDLE_W'(MIN_IDLE));
        end
    endgenerate

    always_comb begin
        w_load         = (r_bit_cnt == '0);
        w_ready        = w_load & active & w_idle_done & ~reset;
        w_take         = w_ready & valid_in;
        w_src          = r_shift;
        w_shift_nxt    = r_shift;
        w_bit_nxt      = 1'b0;
        w_bit_cnt_nxt  = r_bit_cnt + CNT_W'(1);
        w_idle_cnt_nxt = r_idle_cnt;
        w_idl_nxt      = r_idl;

        if (r_bit_cnt == CNT_W'(WIDTH - 1)) begin
            w_bit_cnt_nxt = '0;
        end

        // At a word boundary the new word bypasses the shifter so its first bit goes out now.
        if (w_load) begin
            w_src     = w_take ? data_in : IDLE_VAL;
            w_idl_nxt = ~w_take;
            if (!w_take && !w_idle_done) begin
                w_idle_cnt_nxt = r_idle_cnt + IDLE_W'(1);
            end
        end

        if (LSB_FIRST) begin
            w_bit_nxt   = w_src[0];
            w_shift_nxt = w_src >> 1;
        end else begin
            w_bit_nxt   = w_src[WIDTH-1];
            w_shift_nxt = w_src << 1;
        end
    end

    always_ff @(posedge clk_32f) begin
        if (reset) begin
            r_bit_cnt  <= '0;
            r_idle_cnt <= '0;
            r_shift    <= '0;
            r_data_out <= 1'b0;
            r_idl      <= 1'b1;
        end else begin
            r_bit_cnt  <= w_bit_cnt_nxt;
            r_idle_cnt <= w_idle_cnt_nxt;
            r_shift    <= w_shift_nxt;
            r_data_out <= w_bit_nxt;
            r_idl      <= w_idl_nxt;
        end
    end

    assign ready    = w_ready;
    assign data_out = r_data_out;
    assign IDL      = r_idl;

endmodule
